// File: rtl/load_store_queue_pkg.sv
// Shared constants and types for the load/store queue.
package load_store_queue_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ROB_WIDTH  = 5;

  localparam logic [ROB_WIDTH-1:0] ZERO_ROB = '0;

  // RV32I load/store funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Memory access size encodings (equal to funct3[1:0])
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_MEM
  } lsq_state_e;

  // An operand waiting on a producer: tag==ZERO_ROB means val is valid
  typedef struct packed {
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] val;
  } operand_t;

  // Capture a broadcast value into a pending operand whose tag matches
  function automatic operand_t snoop(
    input operand_t              op,
    input logic [ROB_WIDTH-1:0]  t1,
    input logic [DATA_WIDTH-1:0] v1,
    input logic [ROB_WIDTH-1:0]  t2,
    input logic [DATA_WIDTH-1:0] v2
  );
    operand_t r;
    r = op;
    if (op.tag != ZERO_ROB) begin
      if (op.tag == t1) begin
        r.tag = ZERO_ROB;
        r.val = v1;
      end else if (op.tag == t2) begin
        r.tag = ZERO_ROB;
        r.val = v2;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/load_store_queue_ls_extend.sv
// Load data extension: sign/zero-extends raw memory data per funct3.
module ls_extend
  import load_store_queue_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] value_o
);

  // Select extension mode from the load width/sign code
  always_comb begin
    value_o = rdata_i;
    case (funct3_i)
      F3_LB:   value_o = {{(DATA_WIDTH-8){rdata_i[7]}}, rdata_i[7:0]};
      F3_LH:   value_o = {{(DATA_WIDTH-16){rdata_i[15]}}, rdata_i[15:0]};
      F3_LBU:  value_o = {{(DATA_WIDTH-8){1'b0}}, rdata_i[7:0]};
      F3_LHU:  value_o = {{(DATA_WIDTH-16){1'b0}}, rdata_i[15:0]};
      F3_LW:   value_o = rdata_i;
      default: value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_queue.sv
// Circular load/store queue: in-order issue from head, operand snooping,
// store commit tracking and misbranch flush.
module load_store_queue
  import load_store_queue_pkg::*;
#(
  parameter int LSQ_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_assign_ena,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [ROB_WIDTH-1:0]  in_base_tag,
  input  logic [ROB_WIDTH-1:0]  in_data_tag,
  input  logic [DATA_WIDTH-1:0] in_base_value,
  input  logic [DATA_WIDTH-1:0] in_data_value,
  input  logic [ROB_WIDTH-1:0]  in_rob_tag,
  output logic                  out_full,
  input  logic [ROB_WIDTH-1:0]  in_cdb_rob_tag,
  input  logic [DATA_WIDTH-1:0] in_cdb_value,
  input  logic [ROB_WIDTH-1:0]  in_committed_rob_tag,
  input  logic                  in_misbranch,
  output logic                  out_mem_req,
  output logic                  out_mem_we,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0] out_mem_wdata,
  output logic [1:0]            out_mem_size,
  input  logic                  in_mem_done,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata,
  output logic [ROB_WIDTH-1:0]  out_ls_cdb_rob_tag,
  output logic [DATA_WIDTH-1:0] out_ls_cdb_value
);

  localparam int PTR_W = $clog2(LSQ_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSQ_SIZE);

  logic [LSQ_SIZE-1:0]   valid_q, valid_d, committed_q, committed_d;
  logic [LSQ_SIZE-1:0]   commit_vec, is_store_q;
  logic [2:0]            funct3_q [LSQ_SIZE];
  logic [DATA_WIDTH-1:0] imm_q    [LSQ_SIZE];
  logic [ROB_WIDTH-1:0]  rob_q    [LSQ_SIZE];
  operand_t              base_q   [LSQ_SIZE];
  operand_t              data_q   [LSQ_SIZE];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, scan_idx, off;
  logic [CNT_W-1:0] count_q, count_d, keep;
  logic             keep_found;
  lsq_state_e       state_q, state_d;
  logic             flushed_q, flushed_d;

  logic [DATA_WIDTH-1:0] req_addr_q, req_wdata_q, ls_val_q, ext_value;
  logic                  req_we_q;
  logic [2:0]            req_f3_q;
  logic [ROB_WIDTH-1:0]  req_rob_q, ls_tag_q;

  logic     head_ready, issue, mem_done_now, head_dropped, suppress, pop, bcast, push;
  operand_t new_base, new_data;

  assign out_full = (count_q == FULL_CNT);

  // Store commit matches, merged with already-committed flags
  always_comb begin
    for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
      commit_vec[i] = committed_q[i] | (valid_q[i] && is_store_q[i] &&
                      (in_committed_rob_tag != ZERO_ROB) && (rob_q[i] == in_committed_rob_tag));
    end
  end

  // Count of leading committed entries from head: these survive a misbranch
  always_comb begin
    keep       = count_q;
    keep_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (!keep_found && (CNT_W'(i) < count_q) && !commit_vec[scan_idx]) begin
        keep_found = 1'b1;
        keep       = CNT_W'(i);
      end
    end
  end

  // Head readiness and handshake bookkeeping
  always_comb begin
    head_ready   = valid_q[head_q] && (base_q[head_q].tag == ZERO_ROB) &&
                   (!is_store_q[head_q] || (committed_q[head_q] && (data_q[head_q].tag == ZERO_ROB)));
    issue        = (state_q == ST_IDLE) && (count_q != '0) && !in_misbranch && head_ready;
    mem_done_now = (state_q == ST_WAIT_MEM) && in_mem_done;
    // A flushed in-flight load finishes its handshake but is no longer in the
    // queue, so its completion must neither pop nor broadcast.
    head_dropped = in_misbranch && (keep == '0);
    suppress     = flushed_q || head_dropped;
    pop          = mem_done_now && !suppress;
    bcast        = pop && !req_we_q;
    push         = in_assign_ena && !out_full && !in_misbranch;
    flushed_d    = mem_done_now ? 1'b0 : (flushed_q || ((state_q == ST_WAIT_MEM) && head_dropped));
  end

  // Pointer, count and per-entry flag next state
  always_comb begin
    head_d = head_q + PTR_W'(pop);
    if (in_misbranch) begin
      count_d = keep - CNT_W'(pop);
      tail_d  = head_q + PTR_W'(keep);
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      tail_d  = tail_q + PTR_W'(push);
    end
    off = '0;
    for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
      off            = PTR_W'(i) - head_q;
      valid_d[i]     = valid_q[i];
      committed_d[i] = commit_vec[i];
      if (in_misbranch && ({1'b0, off} >= keep)) begin
        valid_d[i]     = 1'b0;
        committed_d[i] = 1'b0;
      end
      if (pop && (PTR_W'(i) == head_q)) begin
        valid_d[i]     = 1'b0;
        committed_d[i] = 1'b0;
      end
      if (push && (PTR_W'(i) == tail_q)) begin
        valid_d[i]     = 1'b1;
        committed_d[i] = 1'b0;
      end
    end
  end

  assign new_base = snoop(operand_t'{tag: in_base_tag, val: in_base_value},
                          in_cdb_rob_tag, in_cdb_value, ls_tag_q, ls_val_q);
  assign new_data = snoop(operand_t'{tag: in_data_tag, val: in_data_value},
                          in_cdb_rob_tag, in_cdb_value, ls_tag_q, ls_val_q);

  // Entry payload: allocation plus broadcast snooping of pending operands
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LSQ_SIZE; i++) begin
      base_q[i] <= snoop(base_q[i], in_cdb_rob_tag, in_cdb_value, ls_tag_q, ls_val_q);
      data_q[i] <= snoop(data_q[i], in_cdb_rob_tag, in_cdb_value, ls_tag_q, ls_val_q);
      if (push && (tail_q == PTR_W'(i))) begin
        is_store_q[i] <= in_is_store;
        funct3_q[i]   <= in_funct3;
        imm_q[i]      <= in_imm;
        rob_q[i]      <= in_rob_tag;
        base_q[i]     <= new_base;
        data_q[i]     <= new_data;
      end
    end
  end

  // Queue bookkeeping, request capture and load-result broadcast
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      committed_q <= '0;
      flushed_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_we_q    <= 1'b0;
      req_f3_q    <= '0;
      req_rob_q   <= ZERO_ROB;
      ls_tag_q    <= ZERO_ROB;
      ls_val_q    <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      committed_q <= committed_d;
      flushed_q   <= flushed_d;
      if (issue) begin
        req_addr_q  <= base_q[head_q].val + imm_q[head_q];
        req_wdata_q <= is_store_q[head_q] ? data_q[head_q].val : '0;
        req_we_q    <= is_store_q[head_q];
        req_f3_q    <= funct3_q[head_q];
        req_rob_q   <= rob_q[head_q];
      end
      if (bcast) begin
        ls_tag_q <= req_rob_q;
        ls_val_q <= ext_value;
      end else begin
        ls_tag_q <= ZERO_ROB;
        ls_val_q <= '0;
      end
    end
  end

  ls_extend u_ls_extend (
    .rdata_i  (in_mem_rdata),
    .funct3_i (req_f3_q),
    .value_o  (ext_value)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: issue from head, wait for memory completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (issue) state_d = ST_WAIT_MEM;
      ST_WAIT_MEM: if (in_mem_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: request fields held stable while waiting
  always_comb begin
    out_mem_req   = 1'b0;
    out_mem_we    = 1'b0;
    out_mem_addr  = '0;
    out_mem_wdata = '0;
    out_mem_size  = SIZE_BYTE;
    if (state_q == ST_WAIT_MEM) begin
      out_mem_req   = 1'b1;
      out_mem_we    = req_we_q;
      out_mem_addr  = req_addr_q;
      out_mem_wdata = req_wdata_q;
      out_mem_size  = req_f3_q[1:0];
    end
  end

  assign out_ls_cdb_rob_tag = ls_tag_q;
  assign out_ls_cdb_value   = ls_val_q;

endmodule

// File: tb/tb_load_store_queue.sv
// Self-checking bench for load_store_queue: vector table plus directed sequences.
module tb_load_store_queue;
  import load_store_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_assign_ena, in_is_store, in_misbranch, in_mem_done;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm, in_base_value, in_data_value, in_cdb_value, in_mem_rdata;
  logic [4:0]  in_base_tag, in_data_tag, in_rob_tag, in_cdb_rob_tag, in_committed_rob_tag;
  logic        out_full, out_mem_req, out_mem_we;
  logic [31:0] out_mem_addr, out_mem_wdata, out_ls_cdb_value;
  logic [1:0]  out_mem_size;
  logic [4:0]  out_ls_cdb_rob_tag;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  int n_bcast  = 0;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] data;
    logic [4:0]  rob;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [1:0]  e_size;
    logic [31:0] e_wdata;
    logic [4:0]  e_tag;
    logic [31:0] e_val;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  load_store_queue #(.LSQ_SIZE(16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_assign_ena        (in_assign_ena),
    .in_is_store          (in_is_store),
    .in_funct3            (in_funct3),
    .in_imm               (in_imm),
    .in_base_tag          (in_base_tag),
    .in_data_tag          (in_data_tag),
    .in_base_value        (in_base_value),
    .in_data_value        (in_data_value),
    .in_rob_tag           (in_rob_tag),
    .out_full             (out_full),
    .in_cdb_rob_tag       (in_cdb_rob_tag),
    .in_cdb_value         (in_cdb_value),
    .in_committed_rob_tag (in_committed_rob_tag),
    .in_misbranch         (in_misbranch),
    .out_mem_req          (out_mem_req),
    .out_mem_we           (out_mem_we),
    .out_mem_addr         (out_mem_addr),
    .out_mem_wdata        (out_mem_wdata),
    .out_mem_size         (out_mem_size),
    .in_mem_done          (in_mem_done),
    .in_mem_rdata         (in_mem_rdata),
    .out_ls_cdb_rob_tag   (out_ls_cdb_rob_tag),
    .out_ls_cdb_value     (out_ls_cdb_value)
  );

  // Count completed write handshakes and load broadcasts
  always @(posedge clk) begin
    if (out_mem_req && out_mem_we && in_mem_done) n_writes <= n_writes + 1;
    if (out_ls_cdb_rob_tag != 5'd0) n_bcast <= n_bcast + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_assign_ena = 0; in_is_store = 0; in_funct3 = 0; in_imm = 0;
    in_base_tag = 0; in_data_tag = 0; in_base_value = 0; in_data_value = 0;
    in_rob_tag = 0; in_cdb_rob_tag = 0; in_cdb_value = 0; in_committed_rob_tag = 0;
    in_misbranch = 0; in_mem_done = 0; in_mem_rdata = 0;
  endtask

  task automatic do_assign(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                           input logic [4:0] bt, input logic [31:0] bv,
                           input logic [4:0] dt, input logic [31:0] dv, input logic [4:0] rob);
    in_assign_ena = 1; in_is_store = st; in_funct3 = f3; in_imm = imm;
    in_base_tag = bt; in_base_value = bv; in_data_tag = dt; in_data_value = dv; in_rob_tag = rob;
    @(negedge clk);
    in_assign_ena = 0; in_base_tag = 0; in_data_tag = 0; in_rob_tag = 0;
  endtask

  task automatic pulse_cdb(input logic [4:0] tag, input logic [31:0] val);
    in_cdb_rob_tag = tag; in_cdb_value = val;
    @(negedge clk);
    in_cdb_rob_tag = 0; in_cdb_value = 0;
  endtask

  task automatic pulse_commit(input logic [4:0] tag);
    in_committed_rob_tag = tag;
    @(negedge clk);
    in_committed_rob_tag = 0;
  endtask

  task automatic wait_req(input string name, input int maxc);
    int k = 0;
    while (!out_mem_req && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(out_mem_req), 32'd1);
  endtask

  task automatic complete(input logic [31:0] rd);
    in_mem_done = 1; in_mem_rdata = rd;
    @(negedge clk);
    in_mem_done = 0; in_mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0, b0;
    vec_t v;
    //          st    f3      imm            base           data           rob    rdata          addr           sz    wdata          tag    val
    vecs[0] = '{1'b0, F3_LB,  32'hFFFF_FFFC, 32'h0000_0100, 32'h0,         5'd3,  32'h0000_0080, 32'h0000_00FC, 2'd0, 32'h0,         5'd3,  32'hFFFF_FF80};
    vecs[1] = '{1'b0, F3_LBU, 32'h0000_0005, 32'h0000_0200, 32'h0,         5'd4,  32'h1234_5680, 32'h0000_0205, 2'd0, 32'h0,         5'd4,  32'h0000_0080};
    vecs[2] = '{1'b0, F3_LH,  32'h0000_0002, 32'h0000_1000, 32'h0,         5'd6,  32'h0000_8001, 32'h0000_1002, 2'd1, 32'h0,         5'd6,  32'hFFFF_8001};
    vecs[3] = '{1'b0, F3_LHU, 32'h0000_0000, 32'h0000_1000, 32'h0,         5'd8,  32'hABCD_8001, 32'h0000_1000, 2'd1, 32'h0,         5'd8,  32'h0000_8001};
    vecs[4] = '{1'b0, F3_LW,  32'h0000_0020, 32'hFFFF_FFF0, 32'h0,         5'd9,  32'hCAFE_BABE, 32'h0000_0010, 2'd2, 32'h0,         5'd9,  32'hCAFE_BABE};
    vecs[5] = '{1'b1, F3_SW,  32'h0000_0008, 32'h0000_0300, 32'h1122_3344, 5'd10, 32'h0,         32'h0000_0308, 2'd2, 32'h1122_3344, 5'd0,  32'h0};
    vecs[6] = '{1'b1, F3_SB,  32'hFFFF_FFFF, 32'h0000_0400, 32'h0000_00AB, 5'd11, 32'h0,         32'h0000_03FF, 2'd0, 32'h0000_00AB, 5'd0,  32'h0};
    vecs[7] = '{1'b0, F3_LH,  32'h0000_0040, 32'h0000_0000, 32'h0,         5'd12, 32'hFFFF_7FFF, 32'h0000_0040, 2'd1, 32'h0,         5'd12, 32'h0000_7FFF};

    // Reset state
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(out_mem_req), 32'd0);
    check("rst_full", 32'(out_full), 32'd0);
    check("rst_ls_tag", 32'(out_ls_cdb_rob_tag), 32'd0);
    check("rst_count", 32'(dut.count_q), 32'd0);
    rst_n = 1;
    @(negedge clk);

    // Single transactions from the vector table
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      do_assign(v.st, v.f3, v.imm, 5'd0, v.base, 5'd0, v.data, v.rob);
      if (v.st) pulse_commit(v.rob);
      wait_req($sformatf("v%0d_req", i), 10);
      check($sformatf("v%0d_addr", i), out_mem_addr, v.e_addr);
      check($sformatf("v%0d_size", i), 32'(out_mem_size), 32'(v.e_size));
      check($sformatf("v%0d_we", i), 32'(out_mem_we), 32'(v.st));
      check($sformatf("v%0d_wdata", i), out_mem_wdata, v.e_wdata);
      @(negedge clk);
      check($sformatf("v%0d_hold_req", i), 32'(out_mem_req), 32'd1);
      check($sformatf("v%0d_hold_addr", i), out_mem_addr, v.e_addr);
      w0 = n_writes;
      complete(v.rdata);
      check($sformatf("v%0d_bc_tag", i), 32'(out_ls_cdb_rob_tag), 32'(v.e_tag));
      if (!v.st) check($sformatf("v%0d_bc_val", i), out_ls_cdb_value, v.e_val);
      check($sformatf("v%0d_req_drop", i), 32'(out_mem_req), 32'd0);
      check($sformatf("v%0d_writes", i), 32'(n_writes - w0), 32'(v.st));
      @(negedge clk);
      check($sformatf("v%0d_bc_one_cycle", i), 32'(out_ls_cdb_rob_tag), 32'd0);
    end

    // Store waits for data via CDB, then for commit; one write, no broadcast
    w0 = n_writes; b0 = n_bcast;
    do_assign(1'b1, F3_SW, 32'h4, 5'd0, 32'h500, 5'd5, 32'h0, 5'd7);
    pulse_cdb(5'd5, 32'hDEAD);
    @(negedge clk);
    check("sw_wait_commit", 32'(out_mem_req), 32'd0);
    pulse_commit(5'd7);
    wait_req("sw_req", 10);
    check("sw_we", 32'(out_mem_we), 32'd1);
    check("sw_wdata", out_mem_wdata, 32'hDEAD);
    check("sw_addr", out_mem_addr, 32'h504);
    complete(32'h0);
    repeat (2) @(negedge clk);
    check("sw_single_write", 32'(n_writes - w0), 32'd1);
    check("sw_no_bcast", 32'(n_bcast - b0), 32'd0);
    check("sw_count", 32'(dut.count_q), 32'd0);

    // Allocation snoops same-cycle CDB; a queued load snoops the load broadcast
    in_cdb_rob_tag = 5'd12; in_cdb_value = 32'h40;
    do_assign(1'b0, F3_LW, 32'h8, 5'd12, 32'h0, 5'd0, 32'h0, 5'd13);
    in_cdb_rob_tag = 0; in_cdb_value = 0;
    wait_req("snoop_req", 10);
    check("snoop_alloc_addr", out_mem_addr, 32'h48);
    do_assign(1'b0, F3_LW, 32'h10, 5'd13, 32'h0, 5'd0, 32'h0, 5'd14);
    complete(32'h5);
    check("snoop_bc_tag", 32'(out_ls_cdb_rob_tag), 32'd13);
    check("snoop_bc_val", out_ls_cdb_value, 32'h5);
    wait_req("snoop_ls_req", 10);
    check("snoop_ls_addr", out_mem_addr, 32'h15);
    complete(32'h0);
    @(negedge clk);

    // Fill to full, ignored assigns, pop with wrap
    do_reset();
    for (int i = 0; i < 16; i++) do_assign(1'b0, F3_LW, 32'h0, 5'd31, 32'h0, 5'd0, 32'h0, 5'(i + 1));
    check("full_flag", 32'(out_full), 32'd1);
    check("full_count", 32'(dut.count_q), 32'd16);
    check("full_tail_wrap", 32'(dut.tail_q), 32'd0);
    check("full_no_issue", 32'(out_mem_req), 32'd0);
    do_assign(1'b0, F3_LW, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd20);
    check("full_17th_ignored", 32'(dut.count_q), 32'd16);
    pulse_cdb(5'd31, 32'h500);
    wait_req("full_req", 10);
    check("full_addr", out_mem_addr, 32'h500);
    in_mem_done = 1; in_assign_ena = 1; in_rob_tag = 5'd21;
    @(negedge clk);
    in_mem_done = 0; in_assign_ena = 0; in_rob_tag = 0;
    check("full_pop_assign_ignored", 32'(dut.count_q), 32'd15);
    check("full_pop_tail", 32'(dut.tail_q), 32'd0);
    check("full_clear", 32'(out_full), 32'd0);
    do_assign(1'b0, F3_LW, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd22);
    check("wrap_tail", 32'(dut.tail_q), 32'd1);
    check("wrap_count", 32'(dut.count_q), 32'd16);
    for (int k = 0; k < 16; k++) begin
      wait_req($sformatf("drain%0d_req", k), 10);
      complete(32'h0);
    end
    @(negedge clk);
    check("drain_count", 32'(dut.count_q), 32'd0);

    // Misbranch: committed store survives, loads and same-cycle assign dropped
    do_reset();
    do_assign(1'b1, F3_SW, 32'h0, 5'd0, 32'h600, 5'd30, 32'h0, 5'd1);
    for (int i = 0; i < 3; i++) do_assign(1'b0, F3_LW, 32'h0, 5'd29, 32'h0, 5'd0, 32'h0, 5'(i + 2));
    pulse_commit(5'd1);
    check("mb_pre_count", 32'(dut.count_q), 32'd4);
    in_misbranch = 1; in_assign_ena = 1; in_rob_tag = 5'd5;
    @(negedge clk);
    in_misbranch = 0; in_assign_ena = 0; in_rob_tag = 0;
    check("mb_count", 32'(dut.count_q), 32'd1);
    check("mb_tail", 32'(dut.tail_q), 32'd1);
    pulse_cdb(5'd30, 32'h77);
    wait_req("mb_st_req", 10);
    check("mb_st_we", 32'(out_mem_we), 32'd1);
    check("mb_st_wdata", out_mem_wdata, 32'h77);
    check("mb_st_addr", out_mem_addr, 32'h600);
    complete(32'h0);
    pulse_cdb(5'd29, 32'h1);
    repeat (3) @(negedge clk);
    check("mb_loads_gone", 32'(out_mem_req), 32'd0);
    check("mb_final_count", 32'(dut.count_q), 32'd0);

    // In-flight load flushed: handshake finishes, no broadcast
    b0 = n_bcast;
    do_assign(1'b0, F3_LW, 32'h0, 5'd0, 32'h700, 5'd0, 32'h0, 5'd6);
    wait_req("fl_req", 10);
    in_misbranch = 1;
    @(negedge clk);
    in_misbranch = 0;
    check("fl_count", 32'(dut.count_q), 32'd0);
    check("fl_req_held", 32'(out_mem_req), 32'd1);
    check("fl_addr_held", out_mem_addr, 32'h700);
    complete(32'h99);
    check("fl_no_bc", 32'(out_ls_cdb_rob_tag), 32'd0);
    check("fl_req_drop", 32'(out_mem_req), 32'd0);
    @(negedge clk);
    check("fl_bcast_count", 32'(n_bcast - b0), 32'd0);
    check("fl_count_after", 32'(dut.count_q), 32'd0);
    do_assign(1'b0, F3_LW, 32'h0, 5'd0, 32'h710, 5'd0, 32'h0, 5'd8);
    wait_req("fl_next_req", 10);
    check("fl_next_addr", out_mem_addr, 32'h710);
    complete(32'h1);
    check("fl_next_bc", 32'(out_ls_cdb_rob_tag), 32'd8);
    @(negedge clk);

    // Asynchronous reset while waiting on memory
    do_assign(1'b0, F3_LW, 32'h0, 5'd0, 32'h800, 5'd0, 32'h0, 5'd9);
    wait_req("ar_req", 10);
    #2 rst_n = 0;
    #1;
    check("ar_req_low", 32'(out_mem_req), 32'd0);
    check("ar_count", 32'(dut.count_q), 32'd0);
    check("ar_full", 32'(out_full), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("ar_after_req", 32'(out_mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter LSQ_SIZE, default 16, meaning queue depth (a power of two).
REQ-002 SHALL have port clk  in  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_assign_ena  in  1  decoder allocates one entry.
REQ-005 SHALL have port in_is_store  in  1  1=store, 0=load.
REQ-006 SHALL have port in_funct3  in  3  RV32I width/sign code (LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-007 SHALL have port in_imm  in  32  sign-extended offset.
REQ-008 SHALL have ports in_base_tag/in_data_tag  in  5 each  producing ROB tag; 0 means the value is valid.
REQ-009 SHALL have ports in_base_value/in_data_value  in  32 each  operand values.
REQ-010 SHALL have port in_rob_tag  in  5  ROB tag owned by this entry (never 0).
REQ-011 SHALL have port out_full  out  1  no free entry.
REQ-012 SHALL have ports in_cdb_rob_tag  in  5 and in_cdb_value  in  32  ALU broadcast.
REQ-013 SHALL have port in_committed_rob_tag  in  5  ROB store-commit tag; 0 means none.
REQ-014 SHALL have port in_misbranch  in  1  flush request.
REQ-015 SHALL have ports out_mem_req, out_mem_we  out  1 each  memory request, write enable.
REQ-016 SHALL have ports out_mem_addr, out_mem_wdata  out  32 each; out_mem_size  out  2 (0=byte, 1=half, 2=word).
REQ-017 SHALL have ports in_mem_done  in  1 and in_mem_rdata  in  32  memory completion.
REQ-018 SHALL have ports out_ls_cdb_rob_tag  out  5 and out_ls_cdb_value  out  32  load-result broadcast.

Function
REQ-019 SHALL be a circular FIFO with head/tail pointers and a count; pointers wrap modulo LSQ_SIZE.
REQ-020 SHALL drive out_full combinationally as count==LSQ_SIZE; an assignment while full SHALL be ignored, including when a pop occurs in the same cycle.
REQ-021 SHALL, for every stored operand with a nonzero tag equal to a nonzero in_cdb_rob_tag or out_ls_cdb_rob_tag, capture the matching value and clear the tag; an entry being allocated SHALL snoop the same-cycle broadcasts.
REQ-022 SHALL mark a store entry committed when its rob tag equals a nonzero in_committed_rob_tag.
REQ-023 SHALL issue only from head, through a two-state FSM IDLE/WAIT_MEM.
REQ-024 SHALL, in IDLE, issue a load when the base operand is ready, and a store when committed and both operands are ready; the FSM SHALL then enter WAIT_MEM.
REQ-025 SHALL compute out_mem_addr = base + imm modulo 2^32, set out_mem_size = funct3[1:0], and drive out_mem_wdata only for stores.
REQ-026 SHALL hold out_mem_req and all request fields stable in WAIT_MEM until the cycle in_mem_done=1; it SHALL then pop head, return to IDLE, and drop out_mem_req at the next edge.
REQ-027 SHALL, for a completed load, register out_ls_cdb_rob_tag/value for exactly one cycle after done, with the value sign- or zero-extended per funct3; otherwise out_ls_cdb_rob_tag SHALL be 0.
REQ-028 SHALL produce no broadcast for stores.
REQ-029 SHALL, on in_misbranch, discard every uncommitted entry by setting tail to the first uncommitted entry after head; committed stores SHALL survive, and a same-cycle assignment SHALL be ignored.
REQ-030 SHALL let an in-flight load that is flushed in WAIT_MEM finish its memory handshake, then suppress its broadcast and leave the queue unchanged.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously clear count, head, tail, all valid/committed flags and the FSM (to IDLE), and force all outputs to 0 (out_full=0).

Structure
REQ-032 SHALL take DATA_WIDTH, ROB_WIDTH, ZERO_ROB, funct3 codes and size encodings from the shared constant file.
REQ-033 SHALL place load extension in one sub-module, ls_extend (rdata, funct3 -> 32-bit value).

Verification
REQ-034 SHALL cover LB, base=0x100 ready, imm=-4, tag 3, rdata=0x80 -> addr 0xFC, size 0, broadcast tag 3 value 0xFFFFFF80.
REQ-035 SHALL cover SW, data_tag=5 pending: CDB tag 5 value 0xDEAD precedes commit tag 7 -> single write of wdata 0xDEAD, no broadcast.
REQ-036 SHALL cover filling 16 entries -> out_full=1, a 17th assign ignored, then pop and wrap so tail index returns to 0.
REQ-037 SHALL cover misbranch with 1 committed store plus 3 loads queued -> count=1 and the store completes.
REQ-038 SHALL cover rst_n low during WAIT_MEM -> out_mem_req=0 immediately and count=0.
